// File: rtl/gauss_line_feeder.sv
// Upstream feeder for the 5x5 Gaussian line-buffer filter: registers the RGB stream,
// tracks column/row position and flags stream protocol errors.
// Optional window-valid output is built only when GAUSS_FEED_WIN_VALID_EN is defined.
module gauss_line_feeder #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int KSIZE    = 5,
   parameter int CW       = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_sof,
   input  logic          in_valid,
   input  logic [7:0]    in_r,
   input  logic [7:0]    in_g,
   input  logic [7:0]    in_b,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b,
   output logic [CW-1:0] col,
   output logic          buff_en,
   output logic          shift_en,
   output logic [CW-1:0] row,
   output logic          frame_done,
   output logic          win_valid,
   output logic          err
);

   localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, LINE, SHIFT, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
   logic [CW-1:0] col_q, col_d, row_q, row_d, ccnt_q, ccnt_d;
   logic          buff_en_q, buff_en_d;
   logic          shift_en_q, shift_en_d;
   logic          frame_done_q, frame_done_d;
   logic          err_q, err_d;
   logic          accept;
   logic          drop_err;

   // The shift_en cycle belongs to the line turnaround, so pixels there are refused too.
   assign accept   = (state_q == LINE) && !shift_en_q && in_valid && !in_sof;
   assign drop_err = in_valid && !in_sof &&
                     ((state_q == SHIFT) || (state_q == DONE) ||
                      ((state_q == LINE) && shift_en_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_sof) begin
         state_d = LINE;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            LINE:    if (accept && (ccnt_q == H_LAST)) state_d = SHIFT;
            SHIFT:   state_d = (row_q == V_LAST) ? DONE : LINE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      r_d          = r_q;
      g_d          = g_q;
      b_d          = b_q;
      col_d        = col_q;
      row_d        = row_q;
      ccnt_d       = ccnt_q;
      buff_en_d    = 1'b0;
      shift_en_d   = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q;
      if (in_sof) begin
         ccnt_d = '0;
         row_d  = '0;
         if (state_q == IDLE) begin
            col_d = '0;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         if (accept) begin
            r_d       = in_r;
            g_d       = in_g;
            b_d       = in_b;
            col_d     = ccnt_q;
            buff_en_d = 1'b1;
            if (ccnt_q != H_LAST) ccnt_d = ccnt_q + 1'b1;
         end
         if (state_q == SHIFT) begin
            shift_en_d = 1'b1;
            ccnt_d     = '0;
            if (row_q != V_LAST) row_d = row_q + 1'b1;
         end
         if (state_q == DONE) frame_done_d = 1'b1;
         if (drop_err) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
         col_q        <= '0;
         row_q        <= '0;
         ccnt_q       <= '0;
         buff_en_q    <= 1'b0;
         shift_en_q   <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         col_q        <= col_d;
         row_q        <= row_d;
         ccnt_q       <= ccnt_d;
         buff_en_q    <= buff_en_d;
         shift_en_q   <= shift_en_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

`ifdef GAUSS_FEED_WIN_VALID_EN
   // Window is complete once KSIZE-1 rows are buffered and the halo fits horizontally.
   localparam logic [CW-1:0] ROW_MIN = CW'(KSIZE - 1);
   localparam logic [CW-1:0] COL_MIN = CW'(KSIZE / 2);
   localparam logic [CW-1:0] COL_MAX = CW'(H_ACTIVE - 1 - KSIZE / 2);

   logic win_valid_q, win_valid_d;

   always_comb begin
      win_valid_d = accept && (row_q >= ROW_MIN) && (ccnt_q >= COL_MIN) && (ccnt_q <= COL_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win_valid_q <= 1'b0;
      end else begin
         win_valid_q <= win_valid_d;
      end
   end

   assign win_valid = win_valid_q;
`else
   assign win_valid = 1'b0;
`endif

   assign r          = r_q;
   assign g          = g_q;
   assign b          = b_q;
   assign col        = col_q;
   assign row        = row_q;
   assign buff_en    = buff_en_q;
   assign shift_en   = shift_en_q;
   assign frame_done = frame_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_gauss_line_feeder.sv
// Scoreboard bench for gauss_line_feeder: a stream-level model schedules expected
// output events per cycle, a negedge monitor pops and compares them.
module tb_gauss_line_feeder;

   localparam int H  = 32;
   localparam int V  = 6;
   localparam int K  = 5;
   localparam int CW = 13;

   logic          clk = 1'b0;
   logic          rst, in_sof, in_valid;
   logic [7:0]    in_r, in_g, in_b;
   logic [7:0]    r, g, b;
   logic [CW-1:0] col, row;
   logic          buff_en, shift_en, frame_done, win_valid, err;

   gauss_line_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .KSIZE(K), .CW(CW)) dut (
      .clk(clk), .rst(rst), .in_sof(in_sof), .in_valid(in_valid),
      .in_r(in_r), .in_g(in_g), .in_b(in_b),
      .r(r), .g(g), .b(b), .col(col), .buff_en(buff_en), .shift_en(shift_en),
      .row(row), .frame_done(frame_done), .win_valid(win_valid), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = pixel written, 1 = line shift, 2 = frame done
   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] r, g, b;
      int         col;
      int         row;
      logic       win;
   } ev_t;

   typedef struct {
      int   cyc;
      logic val;
   } err_t;

   ev_t  exp_q[$];
   err_t err_q[$];
   int   checks = 0;
   int   fails  = 0;
   bit   started = 0;

   // Stream-level model of the frame position
   bit m_in_frame;
   bit m_frame_over;
   bit m_err;
   int m_cnt, m_row, m_blk_end;

   function automatic logic win_rule(int rw, int cl);
`ifdef GAUSS_FEED_WIN_VALID_EN
      return (rw >= K - 1) && (cl >= K / 2) && (cl <= H - 1 - K / 2);
`else
      return 1'b0;
`endif
   endfunction

   task automatic drop_after(input int s);
      while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].cyc > s) void'(exp_q.pop_back());
   endtask

   task automatic model_step(input bit rs, input bit sf, input bit vl,
                             input logic [7:0] pr, input logic [7:0] pg, input logic [7:0] pb);
      int   t;
      ev_t  e;
      err_t ee;
      t = cyc;
      if (rs) begin
         drop_after(t);
         m_in_frame = 0; m_frame_over = 0; m_err = 0; m_blk_end = -1; m_cnt = 0; m_row = 0;
      end else begin
         if (m_in_frame && m_frame_over && t > m_blk_end) m_in_frame = 0;
         if (sf) begin
            m_err = m_in_frame;
            drop_after(t);
            m_in_frame = 1; m_frame_over = 0; m_blk_end = -1; m_cnt = 0; m_row = 0;
         end else if (m_in_frame && vl) begin
            if (t <= m_blk_end) begin
               m_err = 1;
            end else begin
               e.cyc = t + 1; e.kind = 0; e.r = pr; e.g = pg; e.b = pb;
               e.col = m_cnt; e.row = m_row; e.win = win_rule(m_row, m_cnt);
               exp_q.push_back(e);
               if (m_cnt == H - 1) begin
                  m_cnt = 0;
                  m_blk_end = t + 2;
                  if (m_row == V - 1) begin
                     m_frame_over = 1;
                     e.cyc = t + 2; e.kind = 1; e.row = m_row; exp_q.push_back(e);
                     e.cyc = t + 3; e.kind = 2; exp_q.push_back(e);
                  end else begin
                     m_row++;
                     e.cyc = t + 2; e.kind = 1; e.row = m_row; exp_q.push_back(e);
                  end
               end else begin
                  m_cnt++;
               end
            end
         end
      end
      ee.cyc = t + 1; ee.val = m_err;
      err_q.push_back(ee);
   endtask

   task automatic step(input bit rs, input bit sf, input bit vl);
      logic [7:0] pr, pg, pb;
      pr = 8'($urandom_range(0, 255));
      pg = 8'($urandom_range(0, 255));
      pb = 8'($urandom_range(0, 255));
      rst = rs; in_sof = sf; in_valid = vl; in_r = pr; in_g = pg; in_b = pb;
      model_step(rs, sf, vl, pr, pg, pb);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0);
   endtask

   task automatic send_pixels(input int n, input int gap_pct);
      int sent;
      bit v;
      sent = 0;
      while (sent < n) begin
         v = ($urandom_range(0, 99) >= gap_pct);
         step(0, 0, v);
         if (v) sent++;
      end
   endtask

   task automatic send_line(input int gap_pct);
      send_pixels(H, gap_pct);
      idle(2);
   endtask

   task automatic send_frame(input int gap_pct);
      step(0, 1, 0);
      for (int l = 0; l < V; l++) send_line(gap_pct);
      idle(2);
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   ev_t  mon_e;
   err_t mon_ee;
   logic mon_ok;

   always @(negedge clk) begin
      if (started) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++; fails++;
            $display("FAIL missed_event: kind %0d due cycle %0d never seen, required present",
                     exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (buff_en === 1'b1 || shift_en === 1'b1 || frame_done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
               fails++;
               $display("FAIL unexpected_strobe cycle %0d: got buff_en=%b shift_en=%b frame_done=%b col=%0d row=%0d, required no strobe",
                        cyc, buff_en, shift_en, frame_done, col, row);
            end else begin
               mon_e = exp_q.pop_front();
               case (mon_e.kind)
                  0: mon_ok = buff_en === 1'b1 && shift_en === 1'b0 && frame_done === 1'b0 &&
                              r === mon_e.r && g === mon_e.g && b === mon_e.b &&
                              int'(col) == mon_e.col && int'(row) == mon_e.row &&
                              win_valid === mon_e.win;
                  1: mon_ok = shift_en === 1'b1 && buff_en === 1'b0 && frame_done === 1'b0 &&
                              int'(row) == mon_e.row;
                  default: mon_ok = frame_done === 1'b1 && buff_en === 1'b0 && shift_en === 1'b0;
               endcase
               if (!mon_ok) begin
                  fails++;
                  $display("FAIL event cycle %0d: got be=%b se=%b fd=%b rgb=%h_%h_%h col=%0d row=%0d win=%b, required kind=%0d rgb=%h_%h_%h col=%0d row=%0d win=%b",
                           cyc, buff_en, shift_en, frame_done, r, g, b, col, row, win_valid,
                           mon_e.kind, mon_e.r, mon_e.g, mon_e.b, mon_e.col, mon_e.row, mon_e.win);
               end
            end
         end
         checks++;
         if (buff_en === 1'b1 && shift_en === 1'b1) begin
            fails++;
            $display("FAIL overlap cycle %0d: got buff_en=1 shift_en=1, required not both", cyc);
         end
         if (buff_en !== 1'b1) begin
            checks++;
            if (win_valid !== 1'b0) begin
               fails++;
               $display("FAIL win_idle cycle %0d: got win_valid=%b, required 0", cyc, win_valid);
            end
         end
         if (err_q.size() > 0 && err_q[0].cyc == cyc) begin
            mon_ee = err_q.pop_front();
            checks++;
            if (err !== mon_ee.val) begin
               fails++;
               $display("FAIL err cycle %0d: got %b, required %b", cyc, err, mon_ee.val);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_sof = 1'b0; in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0;
      m_in_frame = 0; m_frame_over = 0; m_err = 0; m_cnt = 0; m_row = 0; m_blk_end = -1;
      repeat (2) @(posedge clk);
      #1;
      started = 1;
      step(1, 0, 0);
      step(1, 0, 0);
      chk("reset_r", int'(r), 0);
      chk("reset_g", int'(g), 0);
      chk("reset_b", int'(b), 0);
      chk("reset_col", int'(col), 0);
      chk("reset_row", int'(row), 0);
      chk("reset_buff_en", int'(buff_en), 0);
      chk("reset_shift_en", int'(shift_en), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_win_valid", int'(win_valid), 0);
      chk("reset_err", int'(err), 0);

      // Pixels before any frame start are ignored
      repeat (5) step(0, 0, 1);

      send_frame(0);
      chk("frame_end_row", int'(row), V - 1);
      chk("frame_end_err", int'(err), 0);

      send_frame(50);
      chk("gapped_frame_err", int'(err), 0);

      // Pixel on the shift_en cycle of the last line, then a clean sof
      step(0, 1, 0);
      for (int l = 0; l < V - 1; l++) send_line(30);
      send_pixels(H, 0);
      step(0, 0, 0);
      step(0, 0, 1);
      idle(3);
      chk("shift_cycle_err_sticky", int'(err), 1);
      step(0, 1, 0);
      chk("sof_clears_err", int'(err), 0);
      for (int l = 0; l < V; l++) send_line(20);
      idle(3);

      // Resync sof in mid-line, with a stray pixel in the first SHIFT cycle afterwards
      step(0, 1, 0);
      send_line(0);
      send_line(0);
      send_pixels(10, 0);
      step(0, 1, 0);
      chk("resync_err", int'(err), 1);
      send_pixels(H, 0);
      step(0, 0, 1);
      idle(1);
      for (int l = 1; l < V; l++) send_line(40);
      idle(4);
      chk("resync_frame_err_held", int'(err), 1);

      // sof on the SHIFT-state cycle suppresses the pending shift
      step(0, 1, 0);
      send_pixels(H, 0);
      step(0, 1, 0);
      for (int l = 0; l < V; l++) send_line(10);
      idle(4);

      // Reset in mid-line
      step(0, 1, 0);
      send_pixels(15, 0);
      step(1, 0, 1);
      chk("midline_rst_buff_en", int'(buff_en), 0);
      chk("midline_rst_col", int'(col), 0);
      chk("midline_rst_row", int'(row), 0);
      chk("midline_rst_r", int'(r), 0);
      chk("midline_rst_err", int'(err), 0);
      idle(3);

      // Random stream with occasional sof and reset
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 999) < 3, $urandom_range(0, 999) < 8, $urandom_range(0, 99) < 75);
      end
      idle(6);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
